// File: rtl/apb_pkg.sv
// apb_pkg -- shared definitions for the APB4 slave.
//   state_e      : transfer FSM states (IDLE, ACCESS)
//   strb_width() : number of byte lanes for a given data width
//   lsb_width()  : byte-offset bits inside one word
//   idx_width()  : word-index bits for a given memory depth
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int lsb_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int mem_depth);
    return $clog2(mem_depth);
  endfunction

endpackage

// File: rtl/apb4_slave_mem.sv
// apb4_slave_mem -- word-organised storage with per-byte-lane write enables
// and a registered (synchronous) read port. Deliberately has no reset so the
// contents survive a reset of the bus logic.
//   clk    : clock
//   we     : write enable, waddr/wdata/wstrb used when high
//   waddr  : write word index
//   wdata  : write data
//   wstrb  : per-byte-lane write strobes
//   re     : read enable, loads rdata from raddr on the rising edge
//   raddr  : read word index
//   rdata  : registered read data, holds between read enables
module apb4_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = idx_width(MEM_DEPTH),
  parameter int STRB_W     = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb4_slave.sv
// apb4_slave -- APB4 memory-backed slave with configurable wait states.
// Build option: define APB4_SLAVE_PSTRB_EN to honour PSTRB on writes; when
// undefined every write updates all byte lanes (APB3 behaviour) and PSTRB is
// accepted but unused.
//   clk, rst_n         : clock, asynchronous active-low reset
//   PADDR              : byte address
//   PSEL/PENABLE/PWRITE: APB select, enable, direction
//   PWDATA/PSTRB       : write data and byte-lane strobes
//   PRDATA             : read data (registered at setup, 0 on error reads)
//   PREADY/PSLVERR     : transfer complete, transfer error
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) seen in
// IDLE. The FSM then sits in ACCESS while the master holds PSEL=PENABLE=1;
// PREADY rises once the wait counter reaches zero and the transfer completes
// on the rising edge where PSEL & PENABLE & PREADY are all high. Dropping PSEL
// during ACCESS abandons the transfer without side effects.
module apb4_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [strb_width(DATA_WIDTH)-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output state_e                        dbg_state
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int LSB    = lsb_width(DATA_WIDTH);
  localparam int IDX_W  = idx_width(MEM_DEPTH);

  // Byte-offset bits must be zero; bits above the index field must be zero.
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
    ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] HI_MASK =
    ADDR_WIDTH'(~((64'd1 << (LSB + IDX_W)) - 64'd1));
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic             rd_ok_q, rd_ok_d;

  logic             setup;
  logic             setup_err;
  logic [IDX_W-1:0] setup_idx;
  logic             mem_we;
  logic             mem_re;
  logic [STRB_W-1:0] mem_strb;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign setup     = PSEL & ~PENABLE;
  assign setup_idx = PADDR[LSB +: IDX_W];
  assign setup_err = ((PADDR & LOW_MASK) != '0) | ((PADDR & HI_MASK) != '0);

  assign PREADY    = (state_q == ACCESS) & (cnt_q == 4'd0);
  assign PSLVERR   = PREADY & err_q;
  // The memory read register has no reset; rd_ok_q masks it so PRDATA reads
  // zero after reset and after an error read.
  assign PRDATA    = rd_ok_q ? mem_rdata : '0;
  assign dbg_state = state_q;

`ifdef APB4_SLAVE_PSTRB_EN
  assign mem_strb = PSTRB;
`else
  logic unused_pstrb;
  assign unused_pstrb = ^PSTRB;
  assign mem_strb = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = WS;
          idx_d   = setup_idx;
          write_d = PWRITE;
          err_d   = setup_err;
          if (!PWRITE) begin
            mem_re  = 1'b1;
            rd_ok_d = ~setup_err;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (PENABLE) begin
          state_d = IDLE;
          mem_we  = write_q & ~err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  apb4_slave_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(idx_q),
    .wdata(PWDATA),
    .wstrb(mem_strb),
    .re   (mem_re),
    .raddr(setup_idx),
    .rdata(mem_rdata)
  );

endmodule
